rocket_launch_ctrl: RTL

Multi-slot rocket scheduler sitting between the ship/fire-button logic and the rocket renderer/collision logic. Allocates up to `NUM_ROCKETS` concurrent rockets from a single fire button, enforces a launch cooldown, and advances each live rocket across the screen on the 1 ms tick. Retires rockets at the right screen edge or on a collision hit. Exports packed per-slot coordinates and active flags for drawing and hit detection.

---
 rtl/rocket_launch_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rocket_launch_ctrl.sv
// Multi-slot rocket scheduler: allocates, advances and retires up to NUM_ROCKETS rockets on the 1 ms tick.
// Optional ROCKET_AUTOFIRE_EN: a held fire button keeps requesting launches (default: rising edges only).
module rocket_launch_ctrl #(
  parameter int NUM_ROCKETS = 4,
  parameter int STEP        = 1,
  parameter int RETIRE_X    = 632,
  parameter int COOLDOWN    = 150
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      fire_button,
  input  logic [1:0]                game_state,
  input  logic [9:0]                x_ship,
  input  logic [9:0]                y_ship,
  input  logic [NUM_ROCKETS-1:0]    hit,
  output logic [NUM_ROCKETS-1:0]    rocket_active,
  output logic [10*NUM_ROCKETS-1:0] x_rockets,
  output logic [10*NUM_ROCKETS-1:0] y_rockets,
  output logic                      launch_pulse,
  output logic                      cooldown_busy
);

  // state  | meaning
  // IDLE   | slot free, position follows the ship every clk
  // FLIGHT | rocket in flight, x advances by STEP per tick
  typedef enum logic {IDLE = 1'b0, FLIGHT = 1'b1} slot_state_t;

  slot_state_t             state_q [NUM_ROCKETS];
  slot_state_t             state_d [NUM_ROCKETS];
  logic [9:0]              x_q     [NUM_ROCKETS];
  logic [9:0]              x_d     [NUM_ROCKETS];
  logic [9:0]              y_q     [NUM_ROCKETS];
  logic [9:0]              y_d     [NUM_ROCKETS];
  logic [NUM_ROCKETS-1:0]  kill_q, kill_d;
  logic [NUM_ROCKETS-1:0]  launch_sel;
  logic                    any_idle;
  logic                    fire_prev_q;
  logic                    fire_pending_q, fire_pending_d;
  logic                    fire_set;
  logic [9:0]              cool_q, cool_d;
  logic                    playing;
  logic                    upd;
  logic                    launch;

  assign playing = (game_state == 2'b01);
  assign upd     = tick & playing;

`ifdef ROCKET_AUTOFIRE_EN
  assign fire_set = fire_button;
`else
  assign fire_set = fire_button & ~fire_prev_q;
`endif

  // Lowest-index slot that is idle at the start of this cycle.
  always_comb begin
    launch_sel = '0;
    any_idle   = 1'b0;
    for (int i = 0; i < NUM_ROCKETS; i++) begin
      if (state_q[i] == IDLE && !any_idle) begin
        launch_sel[i] = 1'b1;
        any_idle      = 1'b1;
      end
    end
  end

  assign launch = upd & fire_pending_q & (cool_q == 10'd0) & any_idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ROCKETS; i++) begin
        state_q[i] <= IDLE;
        x_q[i]     <= 10'd0;
        y_q[i]     <= 10'd0;
      end
      kill_q         <= '0;
      fire_prev_q    <= 1'b0;
      fire_pending_q <= 1'b0;
      cool_q         <= 10'd0;
    end else begin
      for (int i = 0; i < NUM_ROCKETS; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
      end
      kill_q         <= kill_d;
      fire_prev_q    <= fire_button;
      fire_pending_q <= fire_pending_d;
      cool_q         <= cool_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ROCKETS; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      if (!playing) begin
        state_d[i] = IDLE;
      end else if (upd) begin
        case (state_q[i])
          FLIGHT: begin
            if (kill_q[i] || x_q[i] >= 10'(RETIRE_X)) state_d[i] = IDLE;
            else                                      x_d[i] = x_q[i] + 10'(STEP);
          end
          default: if (launch && launch_sel[i]) state_d[i] = FLIGHT;
        endcase
      end
      // A slot idle now or idling next follows the ship; a launch also picks this up.
      if (state_q[i] == IDLE || state_d[i] == IDLE) begin
        x_d[i] = x_ship;
        y_d[i] = y_ship;
      end
      kill_d[i] = (state_q[i] == FLIGHT) && (state_d[i] == FLIGHT) && (kill_q[i] || hit[i]);
    end

    fire_pending_d = fire_pending_q;
    if (launch)   fire_pending_d = 1'b0;
    if (fire_set) fire_pending_d = 1'b1;
    if (!playing) fire_pending_d = 1'b0;

    cool_d = cool_q;
    if (!playing)                       cool_d = 10'd0;
    else if (launch)                    cool_d = 10'(COOLDOWN);
    else if (upd && cool_q != 10'd0)    cool_d = cool_q - 10'd1;
  end

  always_comb begin
    for (int i = 0; i < NUM_ROCKETS; i++) begin
      rocket_active[i]     = (state_q[i] == FLIGHT);
      x_rockets[10*i +: 10] = x_q[i];
      y_rockets[10*i +: 10] = y_q[i];
    end
    launch_pulse  = launch & ~reset;
    cooldown_busy = (cool_q != 10'd0);
  end

endmodule
